// File: rtl/hex_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hex_pkg
// Brief    : Shared constants and types for the six-digit hex display block.
// Revision : 1.0 - initial release
// ============================================================================
package hex_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int DIGIT_W    = 4;

  // All segments dark (segments are active-low)
  localparam logic [6:0] HEX_BLANK = 7'h7F;

  // Controller states
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [6:0]         seg_t;

endpackage
`default_nettype wire

// File: rtl/hex_decoder.sv
`default_nettype none
// ============================================================================
// Module   : hex_decoder
// Brief    : 4-bit value to active-low seven-segment glyph (0-9, A b C d E F).
//            Output bit 0 = segment a ... bit 6 = segment g.
// Revision : 1.0 - initial release
// ============================================================================
module hex_decoder
  import hex_pkg::*;
(
  input  digit_t nibble,
  output seg_t   seg
);

  // Glyph lookup
  always_comb begin
    seg = HEX_BLANK;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = HEX_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/hex_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_ctrl
// Brief    : Two-requester arbiter owning the six seven-segment displays.
//            An accepted 24-bit value is copied into the digit registers one
//            digit per cycle; segment outputs are registered, active-low.
//            Optional feature macro: HEX_BLINK_EN (per-digit blinking driven
//            by blink_mask with a BLINK_DIV-cycle half-period).
// Revision : 1.0 - initial release
// ============================================================================
module hex_display_ctrl
  import hex_pkg::*;
#(
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [23:0] req0_data,
  input  logic [23:0] req1_data,
  input  logic [5:0]  req0_en,
  input  logic [5:0]  req1_en,
  input  logic [5:0]  blink_mask,
  output logic        busy,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  logic [0:0]                            state;
  logic                                  last_grant;
  logic [2:0]                            idx;
  logic [NUM_DIGITS*DIGIT_W-1:0]         shadow_data;
  logic [NUM_DIGITS-1:0]                 shadow_en;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]    digit;
  logic [NUM_DIGITS-1:0]                 en_reg;
  logic [NUM_DIGITS-1:0][6:0]            dec_seg;
  logic [NUM_DIGITS-1:0][6:0]            seg_next;
  logic [NUM_DIGITS-1:0][6:0]            hex_reg;
  logic                                  grant_valid;
  logic                                  grant_sel;

  // Round-robin grant, only offered while idle; a tie goes to the requester
  // that did not win last time
  always_comb begin
    grant_valid = (state == IDLE) && !reset && (|req_valid);
    grant_sel   = 1'b0;
    if (req_valid[0] && req_valid[1]) begin
      grant_sel = ~last_grant;
    end else begin
      grant_sel = req_valid[1];
    end
  end

  assign req_ready = grant_valid ? (grant_sel ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (state == SCAN);

  // Handshake capture and digit-index sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      idx         <= 3'd0;
      shadow_data <= '0;
      shadow_en   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            shadow_data <= grant_sel ? req1_data : req0_data;
            shadow_en   <= grant_sel ? req1_en   : req0_en;
            last_grant  <= grant_sel;
            idx         <= 3'd0;
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (idx == 3'(NUM_DIGITS - 1)) begin
            idx   <= 3'd0;
            state <= IDLE;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Copy one shadow digit and its enable into the display registers per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      digit  <= '0;
      en_reg <= '0;
    end else if (state == SCAN) begin
      digit[idx]  <= shadow_data[idx*DIGIT_W +: DIGIT_W];
      en_reg[idx] <= shadow_en[idx];
    end
  end

`ifdef HEX_BLINK_EN
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CNT_W-1:0] blink_cnt;
  logic             blink_phase;

  // Free-running half-period counter; phase flips on each wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = ^{blink_mask, BLINK_DIV[0]};
`endif

  for (genvar n = 0; n < NUM_DIGITS; n++) begin : g_digit
    hex_decoder u_dec (
      .nibble (digit[n]),
      .seg    (dec_seg[n])
    );
`ifdef HEX_BLINK_EN
    assign seg_next[n] = (!en_reg[n] || (blink_phase && blink_mask[n])) ? HEX_BLANK : dec_seg[n];
`else
    assign seg_next[n] = en_reg[n] ? dec_seg[n] : HEX_BLANK;
`endif
  end

  // Register the segment drive every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      hex_reg <= {NUM_DIGITS{HEX_BLANK}};
    end else begin
      hex_reg <= seg_next;
    end
  end

  assign hex0 = hex_reg[0];
  assign hex1 = hex_reg[1];
  assign hex2 = hex_reg[2];
  assign hex3 = hex_reg[3];
  assign hex4 = hex_reg[4];
  assign hex5 = hex_reg[5];

endmodule
`default_nettype wire

// File: tb/tb_hex_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_display_ctrl
// Brief    : Scoreboard bench for hex_display_ctrl. A reference model predicts
//            grants, busy and the final display of each accepted write; a
//            monitor compares the DUT against those predictions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_display_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v0 = 1'b0;
  logic        v1 = 1'b0;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [23:0] req0_data = '0;
  logic [23:0] req1_data = '0;
  logic [5:0]  req0_en = '0;
  logic [5:0]  req1_en = '0;
  logic [5:0]  blink_mask = '0;
  logic        busy;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

  assign req_valid = {v1, v0};

  hex_display_ctrl #(.BLINK_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_data  (req0_data),
    .req1_data  (req1_data),
    .req0_en    (req0_en),
    .req1_en    (req1_en),
    .blink_mask (blink_mask),
    .busy       (busy),
    .hex0       (hex0),
    .hex1       (hex1),
    .hex2       (hex2),
    .hex3       (hex3),
    .hex4       (hex4),
    .hex5       (hex5)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [23:0] data; logic [5:0] en; } item_t;
  typedef struct packed { logic who; logic [23:0] data; logic [5:0] en; } acc_t;
  typedef struct packed { logic busy; logic [1:0] ready; } cyc_t;

  item_t q0[$];
  item_t q1[$];
  acc_t  acc_q[$];
  cyc_t  cyc_q[$];

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int epoch    = 0;
  int cool     = 0;
  bit act0     = 1'b0;
  bit act1     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    chk_cnt++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Standard seven-segment glyphs, active-low, bit0 = a .. bit6 = g
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [6:0] hex_of(input int n);
    case (n)
      0: return hex0;  1: return hex1;  2: return hex2;
      3: return hex3;  4: return hex4;  default: return hex5;
    endcase
  endfunction

  // Full display is settled 7 edges after the accept edge
  task automatic check_display(input acc_t a, input int ep);
    repeat (8) @(posedge clk);
    #1;
    if (ep != epoch) return;
    for (int n = 0; n < 6; n++)
      check($sformatf("hex%0d", n), 32'(hex_of(n)), 32'(a.en[n] ? glyph(a.data[4*n +: 4]) : 7'h7F));
  endtask

  // Requester 0: present each queued item, hold until accepted
  initial begin : drv0
    item_t it;
    int    wc;
    forever begin
      @(posedge clk); #1;
      if (q0.size() != 0) begin
        it = q0.pop_front();
        act0 = 1'b1;
        req0_data = it.data; req0_en = it.en; v0 = 1'b1;
        wc = 0;
        forever begin
          @(negedge clk); #2;
          if (req_ready[0]) break;
          wc++;
          if (wc > 300) begin fail("req0_accept_wait"); break; end
        end
        @(posedge clk); #1;
        v0 = 1'b0; act0 = 1'b0;
      end
    end
  end

  // Requester 1: same protocol as requester 0
  initial begin : drv1
    item_t it;
    int    wc;
    forever begin
      @(posedge clk); #1;
      if (q1.size() != 0) begin
        it = q1.pop_front();
        act1 = 1'b1;
        req1_data = it.data; req1_en = it.en; v1 = 1'b1;
        wc = 0;
        forever begin
          @(negedge clk); #2;
          if (req_ready[1]) break;
          wc++;
          if (wc > 300) begin fail("req1_accept_wait"); break; end
        end
        @(posedge clk); #1;
        v1 = 1'b0; act1 = 1'b0;
      end
    end
  end

  // Reference model: one write owns the display for 7 cycles; ties alternate
  initial begin : model
    bit   last = 1'b1;
    bit   who;
    cyc_t c;
    acc_t a;
    forever begin
      @(negedge clk);
      c.busy  = (cool > 0);
      c.ready = 2'b00;
      if (reset) begin
        cool = 0;
        last = 1'b1;
      end else if (cool > 0) begin
        cool--;
      end else if (v0 || v1) begin
        who     = (v0 && v1) ? ~last : v1;
        c.ready = who ? 2'b10 : 2'b01;
        a.who   = who;
        a.data  = who ? req1_data : req0_data;
        a.en    = who ? req1_en : req0_en;
        acc_q.push_back(a);
        last = who;
        cool = 6;
      end
      cyc_q.push_back(c);
    end
  end

  // Monitor: per-cycle busy/ready, and final display of every accepted write
  initial begin : mon
    cyc_t c;
    acc_t a;
    forever begin
      @(negedge clk); #1;
      if (cyc_q.size() != 0) begin
        c = cyc_q.pop_front();
        check("busy", 32'(busy), 32'(c.busy));
        check("req_ready", 32'(req_ready), 32'(c.ready));
        if (c.ready != 2'b00 && acc_q.size() != 0) begin
          a = acc_q.pop_front();
          if (req_ready == c.ready) begin
            fork
              begin
                automatic acc_t ta = a;
                automatic int   te = epoch;
                check_display(ta, te);
              end
            join_none
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || act0 || act1 || cool != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) fail("wait_idle");
    repeat (10) @(posedge clk);
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
    $fatal(1);
  end

  initial begin : main
    item_t it;
    int    n;
    logic [6:0] s1 [16];
    logic [6:0] s0 [16];

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    for (int k = 0; k < 6; k++) check("idle_hex", 32'(hex_of(k)), 32'h7F);
    check("idle_ready", 32'(req_ready), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);

    q0.push_back(item_t'{24'h012345, 6'h3F});
    wait_idle();
    q0.push_back(item_t'{24'hFFFFFF, 6'h01});
    wait_idle();
    q0.push_back(item_t'{24'hABCDEF, 6'h3F});
    q1.push_back(item_t'{24'h987654, 6'h2A});
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      it.data = 24'($urandom);
      it.en   = 6'($urandom);
      if ($urandom_range(0, 1) == 0) q0.push_back(it);
      else q1.push_back(it);
      repeat ($urandom_range(0, 8)) @(posedge clk);
    end
    wait_idle();

    // Abort a write mid-scan
    q0.push_back(item_t'{24'h654321, 6'h3F});
    n = 0;
    forever begin
      @(negedge clk); #1;
      if (req_ready[0]) break;
      n++;
      if (n > 100) begin fail("midscan_accept_wait"); break; end
    end
    repeat (3) @(posedge clk);
    #1;
    epoch++;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    for (int k = 0; k < 6; k++) check("abort_hex", 32'(hex_of(k)), 32'h7F);
    check("abort_busy", 32'(busy), 32'h0);

    q0.push_back(item_t'{24'h112233, 6'h3F});
    q1.push_back(item_t'{24'h445566, 6'h3F});
    wait_idle();
    q0.push_back(item_t'{24'h778899, 6'h15});
    q1.push_back(item_t'{24'hAABBCC, 6'h3E});
    wait_idle();

`ifdef HEX_BLINK_EN
    q0.push_back(item_t'{24'h000080, 6'h3F});
    wait_idle();
    blink_mask = 6'b000010;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); #1;
      s1[i] = hex1;
      s0[i] = hex0;
    end
    for (int i = 0; i < 12; i++) begin
      check("blink_hex1", 32'(s1[i+4]), 32'((s1[i] == 7'h7F) ? 7'h00 : 7'h7F));
      check("blink_hex0", 32'(s0[i]), 32'h40);
    end
    blink_mask = 6'b000000;
`else
    s1[0] = '0;
    s0[0] = '0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
